// File: rtl/mcpu_ram_arbiter_if.sv
// Bus bundle between the MCPU core (fetch + load/store units) and the shared RAM.
// The core drives requests through 'master'; the RAM engine answers through 'slave'.
interface mcpu_ram_arbiter_if #(
    parameter int WORD_SIZE  = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  re;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_SIZE-1:0]  datawr;
    logic [WORD_SIZE-1:0]  datard;
    logic                  data_valid;
    logic                  ire;
    logic [ADDR_WIDTH-1:0] instraddr;
    logic [WORD_SIZE-1:0]  instrrd;
    logic                  instr_valid;
    logic                  busy;
    logic                  addr_err;

    modport master (
        output re, we, addr, datawr, ire, instraddr,
        input  datard, data_valid, instrrd, instr_valid, busy, addr_err
    );

    modport slave (
        input  re, we, addr, datawr, ire, instraddr,
        output datard, data_valid, instrrd, instr_valid, busy, addr_err
    );
endinterface

// File: rtl/mcpu_ram_arbiter.sv
// Single-port RAM shared by the MCPU data and fetch ports: round-robin grant,
// programmable wait states, one-cycle valid pulses and out-of-range detection.
module mcpu_ram_arbiter #(
    parameter int WORD_SIZE   = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_SIZE    = 1 << ADDR_WIDTH,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    mcpu_ram_arbiter_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [ADDR_WIDTH:0] RAM_LIMIT = (ADDR_WIDTH+1)'(RAM_SIZE);
    localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_STATES);

    logic [WORD_SIZE-1:0] mem [RAM_SIZE];

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  op_we_q, op_we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
    logic [WORD_SIZE-1:0]  datard_q, datard_d;
    logic [WORD_SIZE-1:0]  instrrd_q, instrrd_d;
    logic                  data_valid_q, data_valid_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  busy_q, busy_d;
    logic                  addr_err_q, addr_err_d;

    logic                  data_req;
    logic                  pick_instr;
    logic                  in_range;
    logic [WORD_SIZE-1:0]  rd_word;
    logic                  mem_we;

    // grant_q / last_grant_q: 1 = instruction port, 0 = data port
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        op_we_d       = op_we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        datard_d      = datard_q;
        instrrd_d     = instrrd_q;
        data_valid_d  = 1'b0;
        instr_valid_d = 1'b0;
        addr_err_d    = 1'b0;
        busy_d        = busy_q;
        mem_we        = 1'b0;

        data_req   = bus.re | bus.we;
        pick_instr = bus.ire & (~data_req | ~last_grant_q);
        in_range   = {1'b0, addr_q} < RAM_LIMIT;
        rd_word    = in_range ? mem[addr_q] : '0;

        case (state_q)
            ST_IDLE: begin
                if (data_req | bus.ire) begin
                    grant_d      = pick_instr;
                    last_grant_d = pick_instr;
                    op_we_d      = ~pick_instr & bus.we;
                    addr_d       = pick_instr ? bus.instraddr : bus.addr;
                    wdata_d      = bus.datawr;
                    cnt_d        = WAIT_LOAD;
                    state_d      = ST_WAIT;
                    busy_d       = 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    addr_err_d = ~in_range;
                    if (op_we_q) begin
                        mem_we       = in_range & ~reset;
                        data_valid_d = 1'b1;
                    end else if (grant_q) begin
                        instrrd_d     = rd_word;
                        instr_valid_d = 1'b1;
                    end else begin
                        datard_d     = rd_word;
                        data_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            op_we_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            datard_q      <= '0;
            instrrd_q     <= '0;
            data_valid_q  <= 1'b0;
            instr_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            op_we_q       <= op_we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            datard_q      <= datard_d;
            instrrd_q     <= instrrd_d;
            data_valid_q  <= data_valid_d;
            instr_valid_q <= instr_valid_d;
            busy_q        <= busy_d;
            addr_err_q    <= addr_err_d;
        end
    end

    // Array keeps its contents across reset; only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.datard      = datard_q;
    assign bus.instrrd     = instrrd_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.busy        = busy_q;
    assign bus.addr_err    = addr_err_q;
endmodule

// File: tb/tb_mcpu_ram_arbiter.sv
// Self-checking bench for mcpu_ram_arbiter: vector table, hand-written corner
// sequences and randomized traffic against a behavioural memory/arbiter model.
module tb_mcpu_ram_arbiter;
    localparam int WS  = 2;
    localparam int RSZ = 200;

    typedef struct {
        bit         d_en;
        bit         d_we;
        logic [7:0] d_addr;
        logic [7:0] d_wd;
        bit         i_en;
        logic [7:0] i_addr;
        bit         instr_first;
        logic [7:0] exp_d;
        bit         exp_d_err;
        logic [7:0] exp_i;
        bit         exp_i_err;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcpu_ram_arbiter_if #(.WORD_SIZE(8), .ADDR_WIDTH(8)) bus ();
    mcpu_ram_arbiter_if #(.WORD_SIZE(8), .ADDR_WIDTH(8)) bus0 ();

    mcpu_ram_arbiter #(.WORD_SIZE(8), .ADDR_WIDTH(8), .RAM_SIZE(RSZ), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    mcpu_ram_arbiter #(.WORD_SIZE(8), .ADDR_WIDTH(8), .RAM_SIZE(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: plain array, last-served port (1 = instruction) and held outputs
    logic [7:0] model_mem [256];
    bit         model_last;
    logic [7:0] model_datard;
    logic [7:0] model_instrrd;

    vec_t table_v [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input bit d_en, input bit d_we, input logic [7:0] d_addr,
                                 input logic [7:0] d_wd, input bit i_en, input logic [7:0] i_addr,
                                 input bit instr_first, input logic [7:0] exp_d, input bit exp_d_err,
                                 input logic [7:0] exp_i, input bit exp_i_err, input string name);
        vec_t v;
        v.d_en = d_en; v.d_we = d_we; v.d_addr = d_addr; v.d_wd = d_wd;
        v.i_en = i_en; v.i_addr = i_addr; v.instr_first = instr_first;
        v.exp_d = exp_d; v.exp_d_err = exp_d_err; v.exp_i = exp_i; v.exp_i_err = exp_i_err;
        v.name = name;
        return v;
    endfunction

    task automatic modelReset();
        model_last    = 1'b1;
        model_datard  = 8'h00;
        model_instrrd = 8'h00;
    endtask

    task automatic doReset();
        bus.re = 0; bus.we = 0; bus.ire = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    // Issues the request(s) of one vector at a negedge and follows them to completion
    task automatic applyStimulus(input vec_t v);
        int  cyc, prev_cyc, busy_cnt, served;
        bit  d_pend, i_pend, first_instr, exp_instr;
        d_pend = v.d_en;
        i_pend = v.i_en;
        first_instr = (v.d_en && v.i_en) ? v.instr_first : v.i_en;
        bus.re = v.d_en & ~v.d_we;
        bus.we = v.d_en & v.d_we;
        bus.addr = v.d_addr;
        bus.datawr = v.d_wd;
        bus.ire = v.i_en;
        bus.instraddr = v.i_addr;
        cyc = 0; prev_cyc = 0; busy_cnt = 0; served = 0;
        while ((d_pend || i_pend) && cyc < 4 * (WS + 2) + 10) begin
            @(negedge clk);
            cyc++;
            if (bus.data_valid || bus.instr_valid) begin
                served++;
                exp_instr = (served == 1) ? first_instr : ~first_instr;
                checkOutput({v.name, " valid_sel"}, 32'({bus.data_valid, bus.instr_valid}),
                            exp_instr ? 32'b01 : 32'b10);
                checkOutput({v.name, " latency"}, 32'(cyc - prev_cyc), 32'(WS + 2));
                checkOutput({v.name, " busy_cycles"}, 32'(busy_cnt), 32'(WS + 1));
                if (exp_instr) begin
                    checkOutput({v.name, " instrrd"}, 32'(bus.instrrd), 32'(v.exp_i));
                    checkOutput({v.name, " addr_err_i"}, 32'(bus.addr_err), 32'(v.exp_i_err));
                    checkOutput({v.name, " datard_hold"}, 32'(bus.datard), 32'(model_datard));
                    model_instrrd = v.exp_i;
                    bus.ire = 0;
                    i_pend = 0;
                    model_last = 1'b1;
                end else begin
                    checkOutput({v.name, " datard"}, 32'(bus.datard), 32'(v.exp_d));
                    checkOutput({v.name, " addr_err_d"}, 32'(bus.addr_err), 32'(v.exp_d_err));
                    checkOutput({v.name, " instrrd_hold"}, 32'(bus.instrrd), 32'(model_instrrd));
                    model_datard = v.exp_d;
                    if (v.d_we && v.d_addr < RSZ) model_mem[v.d_addr] = v.d_wd;
                    bus.re = 0;
                    bus.we = 0;
                    d_pend = 0;
                    model_last = 1'b0;
                end
                prev_cyc = cyc;
                busy_cnt = 0;
            end else if (bus.busy) begin
                busy_cnt++;
            end
        end
        if (d_pend || i_pend) checkOutput({v.name, " timeout"}, 32'(served), 32'(v.d_en + v.i_en));
        bus.re = 0; bus.we = 0; bus.ire = 0;
    endtask

    task automatic dut0Write(input logic [7:0] a, input logic [7:0] d);
        int k;
        bus0.we = 1; bus0.addr = a; bus0.datawr = d;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus0.data_valid && k < 10);
        checkOutput("dut0 write_ack", 32'(bus0.data_valid), 32'd1);
        bus0.we = 0;
    endtask

    initial begin
        int cyc, got, first_cyc;
        bit exp_i, first_instr;
        vec_t v;
        logic [7:0] exp_i_val;

        bus.re = 0; bus.we = 0; bus.ire = 0; bus.addr = 0; bus.datawr = 0; bus.instraddr = 0;
        bus0.re = 0; bus0.we = 0; bus0.ire = 0; bus0.addr = 0; bus0.datawr = 0; bus0.instraddr = 0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset datard", 32'(bus.datard), 0);
        checkOutput("reset instrrd", 32'(bus.instrrd), 0);
        checkOutput("reset data_valid", 32'(bus.data_valid), 0);
        checkOutput("reset instr_valid", 32'(bus.instr_valid), 0);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset addr_err", 32'(bus.addr_err), 0);
        reset = 1'b0;

        //               d_en we addr   wd     i_en iaddr  ifst exp_d  e  exp_i  e
        table_v.push_back(mkv(1, 1, 8'h10, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, "wr_a5"));
        table_v.push_back(mkv(1, 0, 8'h10, 8'h00, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0, "rd_a5"));
        table_v.push_back(mkv(1, 1, 8'h10, 8'h5A, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0, "wr_5a"));
        table_v.push_back(mkv(1, 1, 8'h20, 8'h3C, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0, "wr_3c"));
        table_v.push_back(mkv(0, 0, 8'h00, 8'h00, 1, 8'h20, 0, 8'h00, 0, 8'h3C, 0, "fetch_3c"));
        table_v.push_back(mkv(1, 1, 8'hC7, 8'h42, 0, 8'h00, 0, 8'hA5, 0, 8'h00, 0, "wr_top"));
        table_v.push_back(mkv(1, 0, 8'hC7, 8'h00, 0, 8'h00, 0, 8'h42, 0, 8'h00, 0, "rd_top"));
        table_v.push_back(mkv(0, 0, 8'h00, 8'h00, 1, 8'hC8, 0, 8'h00, 0, 8'h00, 1, "fetch_oor"));
        table_v.push_back(mkv(1, 0, 8'hFA, 8'h00, 0, 8'h00, 0, 8'h00, 1, 8'h00, 0, "rd_oor"));
        table_v.push_back(mkv(1, 1, 8'h30, 8'h11, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, "wr_11"));
        foreach (table_v[i]) applyStimulus(table_v[i]);

        // Simultaneous requests straight after reset: data wins the first tie
        doReset();
        applyStimulus(mkv(1, 0, 8'h10, 8'h00, 1, 8'h20, 0, 8'h5A, 0, 8'h3C, 0, "tie_after_reset"));

        // Both requests held continuously: strict alternation, never coincident
        bus.re = 1; bus.addr = 8'h10; bus.ire = 1; bus.instraddr = 8'h20;
        got = 0; cyc = 0;
        while (got < 8 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.data_valid || bus.instr_valid) begin
                exp_i = ~model_last;
                checkOutput("rr order", 32'({bus.data_valid, bus.instr_valid}), exp_i ? 32'b01 : 32'b10);
                if (exp_i) checkOutput("rr instrrd", 32'(bus.instrrd), 32'h3C);
                else       checkOutput("rr datard", 32'(bus.datard), 32'h5A);
                model_last = exp_i;
                got++;
            end
        end
        checkOutput("rr grants", 32'(got), 32'd8);
        bus.re = 0; bus.ire = 0;
        model_datard = 8'h5A; model_instrrd = 8'h3C;

        // Reset during the first wait cycle aborts a pending write
        bus.we = 1; bus.addr = 8'h30; bus.datawr = 8'h77;
        @(negedge clk);
        checkOutput("abort busy", 32'(bus.busy), 1);
        reset = 1'b1; bus.we = 0;
        @(negedge clk);
        checkOutput("abort datard", 32'(bus.datard), 0);
        checkOutput("abort instrrd", 32'(bus.instrrd), 0);
        checkOutput("abort busy_clr", 32'(bus.busy), 0);
        reset = 1'b0;
        modelReset();
        got = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.data_valid) got++;
        end
        checkOutput("abort no_valid", 32'(got), 0);
        applyStimulus(mkv(1, 0, 8'h30, 8'h00, 0, 8'h00, 0, 8'h11, 0, 8'h00, 0, "abort_readback"));

        // Zero wait states: back-to-back reads with re held
        dut0Write(8'h01, 8'h0A);
        dut0Write(8'h02, 8'h0B);
        bus0.re = 1; bus0.addr = 8'h01;
        got = 0; cyc = 0; first_cyc = 0;
        while (got < 2 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (bus0.data_valid) begin
                got++;
                if (got == 1) begin
                    checkOutput("ws0 first", 32'(bus0.datard), 32'h0A);
                    first_cyc = cyc;
                    bus0.addr = 8'h02;
                end else begin
                    checkOutput("ws0 second", 32'(bus0.datard), 32'h0B);
                    checkOutput("ws0 spacing", 32'(cyc - first_cyc), 32'd2);
                end
            end
        end
        checkOutput("ws0 count", 32'(got), 32'd2);
        bus0.re = 0;

        // Fill the whole implemented range, then an out-of-range write must disturb nothing
        for (int a = 0; a < RSZ; a++) begin
            applyStimulus(mkv(1, 1, 8'(a), 8'($urandom), 0, 8'h00, 0, model_datard, 0, 8'h00, 0, "fill"));
        end
        applyStimulus(mkv(1, 1, 8'd250, 8'hFF, 0, 8'h00, 0, model_datard, 1, 8'h00, 0, "wr_oor"));
        for (int a = 0; a < RSZ; a++) begin
            applyStimulus(mkv(0, 0, 8'h00, 8'h00, 1, 8'(a), 0, 8'h00, 0, model_mem[a], 0, "verify"));
        end

        // Randomized traffic against the model
        for (int t = 0; t < 120; t++) begin
            v.d_en = 1'($urandom);
            v.i_en = v.d_en ? 1'($urandom) : 1'b1;
            v.d_we = 1'($urandom);
            v.d_addr = 8'($urandom);
            v.d_wd = 8'($urandom);
            v.i_addr = ($urandom_range(0, 3) == 0) ? v.d_addr : 8'($urandom);
            first_instr = (v.d_en && v.i_en) ? model_last == 1'b0 : v.i_en;
            v.instr_first = first_instr;
            v.exp_d_err = v.d_addr >= RSZ;
            v.exp_i_err = v.i_addr >= RSZ;
            if (v.d_we) v.exp_d = model_datard;
            else        v.exp_d = (v.d_addr < RSZ) ? model_mem[v.d_addr] : 8'h00;
            exp_i_val = (v.i_addr < RSZ) ? model_mem[v.i_addr] : 8'h00;
            if (v.d_en && v.d_we && !first_instr && v.d_addr == v.i_addr && v.d_addr < RSZ)
                exp_i_val = v.d_wd;
            v.exp_i = exp_i_val;
            v.name = "random";
            applyStimulus(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
